// File: rtl/buf_bram_arbiter.sv
// -----------------------------------------------------------------------------
// buf_bram_arbiter
//
// Shares the single data port of the buffer BRAM between the CPU load/store
// path and a read-only stream engine (scanout/DMA). One access is issued per
// cycle. Reads are tagged so the returning BRAM data is steered to the right
// requester READ_LAT cycles after issue.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until it sees *_gnt high in the same cycle; the access is issued in that
// cycle and the request may change on the following cycle. Responses carry no
// back-pressure: *_rvalid is a single-cycle strobe with *_rdata.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   cpu_req/we/addr/wstrb/wdata   CPU byte-addressed access request
//   cpu_gnt                 CPU access accepted this cycle (combinational)
//   cpu_rvalid/cpu_rdata    CPU load response (raw little-endian word)
//   cpu_err                 one-cycle pulse after an out-of-window access
//   strm_req/strm_addr      stream word-address read request
//   strm_gnt                stream request accepted this cycle (combinational)
//   strm_rvalid/strm_rdata  stream read response
//   bram_en/we/addr/din     BRAM port controls
//   bram_dout               BRAM read data, valid READ_LAT cycles after bram_en
//   perf_cpu_stall          cycles the CPU waited (0 unless ARB_PERF_CNT_EN)
//   perf_strm_grant         stream grant cycles   (0 unless ARB_PERF_CNT_EN)
//
// Build option: define ARB_PERF_CNT_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module buf_bram_arbiter #(
    parameter logic [31:0] BUF_BRAM_START = 32'h0100_0000,
    parameter logic [31:0] BUF_BRAM_END   = 32'h013F_FF00,
    parameter int          ADDR_W         = 20,
    parameter int          READ_LAT       = 1,   // 1 or 2
    parameter int          STARVE_LIMIT   = 4    // 1..255
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [3:0]        cpu_wstrb,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,

    input  logic              strm_req,
    input  logic [ADDR_W-1:0] strm_addr,
    output logic              strm_gnt,
    output logic              strm_rvalid,
    output logic [31:0]       strm_rdata,

    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout,

    output logic [31:0]       perf_cpu_stall,
    output logic [31:0]       perf_strm_grant
);

    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_CPU     = 2'd1,
        TAG_CPU_BAD = 2'd2,
        TAG_STRM    = 2'd3
    } tag_e;

    localparam logic [31:0] BAD_DATA   = 32'hBAD0_0BAD;
    localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // CPU address decode
    // ------------------------------------------------------------------
    logic              in_range;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] cpu_word;
    logic              unused_offset_bits;

    assign in_range = (cpu_addr >= BUF_BRAM_START) && (cpu_addr <= BUF_BRAM_END);
    assign offset   = cpu_addr - BUF_BRAM_START;
    assign cpu_word = offset[ADDR_W+1:2];
    // Byte offset and bits above the BRAM depth do not select a word.
    assign unused_offset_bits = ^{offset[31:ADDR_W+2], offset[1:0]};

    // ------------------------------------------------------------------
    // Arbitration and BRAM port drive
    // ------------------------------------------------------------------
    logic [7:0] starve_cnt;
    logic       strm_win;
    tag_e       issue_tag;
    logic       err_d;

    always_comb begin
        strm_win  = strm_req && (!cpu_req || (starve_cnt == STARVE_MAX));
        strm_gnt  = strm_win;
        cpu_gnt   = cpu_req && !strm_win;
        err_d     = cpu_gnt && !in_range;
        bram_en   = 1'b0;
        bram_we   = 4'b0000;
        bram_addr = '0;
        bram_din  = 32'h0;
        issue_tag = TAG_NONE;
        if (strm_win) begin
            bram_en   = 1'b1;
            bram_addr = strm_addr;
            issue_tag = TAG_STRM;
        end else if (cpu_req) begin
            if (in_range) begin
                bram_en   = 1'b1;
                bram_addr = cpu_word;
                if (cpu_we) begin
                    bram_we  = cpu_wstrb;
                    bram_din = cpu_wdata;
                end else begin
                    issue_tag = TAG_CPU;
                end
            end else if (!cpu_we) begin
                // Out-of-window load never touches the BRAM but still
                // answers on the normal schedule with a marker word.
                issue_tag = TAG_CPU_BAD;
            end
        end
    end

    // Counts consecutive cycles the stream asked and lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 8'd0;
        end else if (!strm_req || strm_gnt) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Response tag pipeline
    // ------------------------------------------------------------------
    tag_e tag_q [READ_LAT];
    tag_e out_tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LAT; i++) tag_q[i] <= TAG_NONE;
        end else begin
            tag_q[0] <= issue_tag;
            for (int i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign out_tag = tag_q[READ_LAT-1];

    // rvalid decodes a registered tag only. The BRAM word is only valid in
    // the output-stage cycle, so it is forwarded then and captured so rdata
    // keeps its value between responses.
    logic [31:0] cpu_rdata_q;
    logic [31:0] strm_rdata_q;
    logic        err_q;

    assign cpu_rvalid  = (out_tag == TAG_CPU) || (out_tag == TAG_CPU_BAD);
    assign strm_rvalid = (out_tag == TAG_STRM);
    assign cpu_err     = err_q;

    always_comb begin
        cpu_rdata  = cpu_rdata_q;
        strm_rdata = strm_rdata_q;
        case (out_tag)
            TAG_CPU:     cpu_rdata  = bram_dout;
            TAG_CPU_BAD: cpu_rdata  = BAD_DATA;
            TAG_STRM:    strm_rdata = bram_dout;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata_q  <= 32'h0;
            strm_rdata_q <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            cpu_rdata_q  <= cpu_rdata;
            strm_rdata_q <= strm_rdata;
            err_q        <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] sgrant_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt  <= 32'h0;
            sgrant_cnt <= 32'h0;
        end else begin
            if (cpu_req && !cpu_gnt) stall_cnt  <= stall_cnt + 32'd1;
            if (strm_gnt)            sgrant_cnt <= sgrant_cnt + 32'd1;
        end
    end

    assign perf_cpu_stall  = stall_cnt;
    assign perf_strm_grant = sgrant_cnt;
`else
    assign perf_cpu_stall  = 32'h0;
    assign perf_strm_grant = 32'h0;
`endif

endmodule

// File: tb/tb_buf_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buf_bram_arbiter
//
// Bench for buf_bram_arbiter. A behavioural BRAM model hangs on the port; a
// reference model (word memory, lost-cycle count, response queues keyed by due
// cycle) predicts grants, BRAM controls and responses every cycle. Inputs are
// driven 1 ns after the rising edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_buf_bram_arbiter;

    localparam int          ADDR_W       = 20;
    localparam int          READ_LAT     = 1;
    localparam int          STARVE_LIMIT = 4;
    localparam logic [31:0] START_A      = 32'h0100_0000;
    localparam logic [31:0] END_A        = 32'h013F_FF00;
    localparam logic [31:0] BAD          = 32'hBAD0_0BAD;
`ifdef ARB_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
    logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]        cpu_wstrb;
    logic              strm_req, strm_gnt, strm_rvalid;
    logic [ADDR_W-1:0] strm_addr;
    logic [31:0]       strm_rdata;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din, bram_dout;
    logic [31:0]       perf_cpu_stall, perf_strm_grant;

    buf_bram_arbiter #(
        .BUF_BRAM_START(START_A),
        .BUF_BRAM_END  (END_A),
        .ADDR_W        (ADDR_W),
        .READ_LAT      (READ_LAT),
        .STARVE_LIMIT  (STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wstrb      (cpu_wstrb),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .cpu_err        (cpu_err),
        .strm_req       (strm_req),
        .strm_addr      (strm_addr),
        .strm_gnt       (strm_gnt),
        .strm_rvalid    (strm_rvalid),
        .strm_rdata     (strm_rdata),
        .bram_en        (bram_en),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .bram_din       (bram_din),
        .bram_dout      (bram_dout),
        .perf_cpu_stall (perf_cpu_stall),
        .perf_strm_grant(perf_strm_grant)
    );

    // ---------------- helpers ----------------
    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural BRAM ----------------
    logic [31:0] bram_mem [int];
    logic [31:0] dpipe [READ_LAT];

    function automatic logic [31:0] bram_rd(input int w);
        return bram_mem.exists(w) ? bram_mem[w] : init_word(w);
    endfunction

    initial for (int i = 0; i < READ_LAT; i++) dpipe[i] = 32'h0;

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we != 4'b0000)
                bram_mem[int'(bram_addr)] = merge(bram_rd(int'(bram_addr)), bram_din, bram_we);
            else
                dpipe[0] <= bram_rd(int'(bram_addr));
        end
        for (int i = 1; i < READ_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bram_dout = dpipe[READ_LAT-1];

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic [31:0] ref_mem [int];
    resp_t       cpu_exp_q[$];
    resp_t       strm_exp_q[$];
    int          err_exp_q[$];
    int          cyc;
    int          lost;
    int          m_stall, m_sgrant;
    logic [31:0] last_c, last_s;
    logic        last_cpu_win;
    int          checks, failures;

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        cpu_exp_q.delete();
        strm_exp_q.delete();
        err_exp_q.delete();
        lost         = 0;
        m_stall      = 0;
        m_sgrant     = 0;
        last_c       = 32'h0;
        last_s       = 32'h0;
        last_cpu_win = 1'b0;
    endtask

    // One cycle: drive, check at negedge against the model, advance.
    task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr,
                        input logic [3:0] cstrb, input logic [31:0] cdata,
                        input logic sreq, input logic [ADDR_W-1:0] saddr);
        logic        s_win, c_win, in_rng, exp_cv, exp_sv, exp_err;
        logic [31:0] off;
        int          w;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wstrb = cstrb;
        cpu_wdata = cdata; strm_req = sreq; strm_addr = saddr;
        @(negedge clk);
        s_win  = sreq && (!creq || lost == STARVE_LIMIT);
        c_win  = creq && !s_win;
        in_rng = (caddr >= START_A) && (caddr <= END_A);
        off    = (caddr - START_A) / 32'd4;
        w      = int'(off % (32'd1 << ADDR_W));

        check("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, c_win});
        check("strm_gnt", {31'b0, strm_gnt}, {31'b0, s_win});
        check("bram_en", {31'b0, bram_en}, {31'b0, s_win || (c_win && in_rng)});
        check("bram_we", {28'b0, bram_we}, (c_win && in_rng && cwe) ? {28'b0, cstrb} : 32'h0);
        if (s_win) check("bram_addr_s", {12'b0, bram_addr}, {12'b0, saddr});
        if (c_win && in_rng) check("bram_addr_c", {12'b0, bram_addr}, 32'(w));
        if (c_win && in_rng && cwe) check("bram_din", bram_din, cdata);

        exp_cv = (cpu_exp_q.size() > 0) && (cpu_exp_q[0].due == cyc);
        if (exp_cv) begin last_c = cpu_exp_q[0].data; cpu_exp_q.delete(0); end
        exp_sv = (strm_exp_q.size() > 0) && (strm_exp_q[0].due == cyc);
        if (exp_sv) begin last_s = strm_exp_q[0].data; strm_exp_q.delete(0); end
        exp_err = (err_exp_q.size() > 0) && (err_exp_q[0] == cyc);
        if (exp_err) err_exp_q.delete(0);
        check("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, exp_cv});
        check("cpu_rdata", cpu_rdata, last_c);
        check("strm_rvalid", {31'b0, strm_rvalid}, {31'b0, exp_sv});
        check("strm_rdata", strm_rdata, last_s);
        check("cpu_err", {31'b0, cpu_err}, {31'b0, exp_err});
        check("perf_stall", perf_cpu_stall, PERF_ON ? 32'(m_stall) : 32'h0);
        check("perf_sgrant", perf_strm_grant, PERF_ON ? 32'(m_sgrant) : 32'h0);

        if (c_win) begin
            if (in_rng) begin
                if (cwe) ref_mem[w] = merge(ref_rd(w), cdata, cstrb);
                else cpu_exp_q.push_back('{due: cyc + READ_LAT, data: ref_rd(w)});
            end else begin
                err_exp_q.push_back(cyc + 1);
                if (!cwe) cpu_exp_q.push_back('{due: cyc + READ_LAT, data: BAD});
            end
        end
        if (s_win) strm_exp_q.push_back('{due: cyc + READ_LAT, data: ref_rd(int'(saddr))});
        if (sreq && !s_win) lost = (lost < STARVE_LIMIT) ? lost + 1 : STARVE_LIMIT;
        else lost = 0;
        if (creq && !c_win) m_stall++;
        if (s_win) m_sgrant++;
        last_cpu_win = c_win;

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, '0);
    endtask

    // Asserts reset for one cycle (called 1 ns after a rising edge).
    task automatic do_reset();
        cpu_req = 1'b0; strm_req = 1'b0; cpu_we = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        check("rst_strm_rvalid", {31'b0, strm_rvalid}, 32'h0);
        check("rst_cpu_err", {31'b0, cpu_err}, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_strm_rdata", strm_rdata, 32'h0);
        check("rst_bram_en", {31'b0, bram_en}, 32'h0);
        check("rst_perf_stall", perf_cpu_stall, 32'h0);
        check("rst_perf_sgrant", perf_strm_grant, 32'h0);
        model_clear();
        @(posedge clk);
        cyc++;
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_caddr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return START_A - 32'd1 - 32'($urandom_range(0, 255));
        if (r == 1) return END_A + 32'd1 + 32'($urandom_range(0, 255));
        if (r == 2) return END_A - 32'd4 * 32'($urandom_range(0, 3));
        if (r == 3) return $urandom;
        return START_A + 32'($urandom_range(0, 63));
    endfunction

    // ---------------- stimulus ----------------
    logic              c_req, c_we, s_req;
    logic [31:0]       c_addr, c_data;
    logic [3:0]        c_strb;
    logic [ADDR_W-1:0] s_addr;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        model_clear();
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wstrb = 4'h0;
        cpu_wdata = 32'h0; strm_req = 1'b0; strm_addr = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Load from word 4 returning 0x11223344.
        bram_mem[4] = 32'h1122_3344;
        ref_mem[4]  = 32'h1122_3344;
        step(1'b1, 1'b0, 32'h0100_0010, 4'h0, 32'h0, 1'b0, '0);
        idle();
        check("load_w4_data", cpu_rdata, 32'h1122_3344);

        // Partial store to word 2, then read it back.
        step(1'b1, 1'b1, 32'h0100_0008, 4'b0011, 32'hAABB_CCDD, 1'b0, '0);
        step(1'b1, 1'b0, 32'h0100_0008, 4'h0, 32'h0, 1'b0, '0);
        idle();

        // Both requesters held: stream wins once every STARVE_LIMIT+1 cycles.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 32'h0100_0010, 4'h0, 32'h0, 1'b1, 20'd7);
        idle();
        idle();
        check("perf_sgrant_10", perf_strm_grant, PERF_ON ? 32'd2 : 32'd0);
        check("perf_stall_10", perf_cpu_stall, PERF_ON ? 32'd2 : 32'd0);

        // Window boundaries and out-of-window accesses.
        step(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 1'b0, '0);
        idle();
        check("oor_rdata", cpu_rdata, BAD);
        step(1'b1, 1'b1, 32'h0000_0100, 4'hF, 32'h1234_5678, 1'b0, '0);
        step(1'b1, 1'b0, END_A, 4'h0, 32'h0, 1'b0, '0);
        step(1'b1, 1'b0, END_A + 32'd1, 4'h0, 32'h0, 1'b0, '0);
        step(1'b1, 1'b0, START_A - 32'd1, 4'h0, 32'h0, 1'b0, '0);
        step(1'b1, 1'b0, START_A, 4'h0, 32'h0, 1'b1, 20'hFFFC0);
        idle();
        idle();

        // Reset while a load is in flight: its response must vanish.
        step(1'b1, 1'b0, 32'h0100_0010, 4'h0, 32'h0, 1'b0, '0);
        do_reset();
        idle();
        idle();

        // Randomized traffic; requests are held until granted.
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_strb = 4'h0; c_data = 32'h0;
        s_req = 1'b0; s_addr = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(c_req && !last_cpu_win)) begin
                c_req  = ($urandom_range(0, 9) < 7);
                c_we   = $urandom_range(0, 2) == 0;
                c_addr = rand_caddr();
                c_strb = 4'($urandom_range(0, 15));
                c_data = $urandom;
            end
            if (!(s_req && !strm_gnt)) begin
                s_req  = $urandom_range(0, 1) == 1;
                s_addr = ($urandom_range(0, 9) == 0) ? 20'hFFFC0 : 20'($urandom_range(0, 15));
            end
            step(c_req, c_we, c_addr, c_strb, c_data, s_req, s_addr);
        end
        for (int i = 0; i < 3; i++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
